// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_pkg : default widths, pipeline latency and complex pack/unpack helpers  |
// |           shared by the radix-4 transform blocks (fft4 / ifft4).            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package fft_pkg;

  localparam int NB_INPUT_DEF   = 10;
  localparam int NBF_INPUT_DEF  = 7;
  localparam int NB_OUTPUT_DEF  = 8;
  localparam int NBF_OUTPUT_DEF = 7;
  localparam int LATENCY        = 4;

  // A complex word is {re, im}, each nb bits wide; the helpers work on up to
  // 32-bit components held in a 64-bit container.
  function automatic logic signed [31:0] cplx_re(input logic [63:0] x, input int nb);
    logic signed [31:0] r;
    r = signed'(32'(x >> nb));
    r = (r <<< (32 - nb)) >>> (32 - nb);
    return r;
  endfunction

  function automatic logic signed [31:0] cplx_im(input logic [63:0] x, input int nb);
    logic signed [31:0] r;
    r = signed'(32'(x));
    r = (r <<< (32 - nb)) >>> (32 - nb);
    return r;
  endfunction

  function automatic logic [63:0] cplx_pack(input logic signed [31:0] re,
                                            input logic signed [31:0] im,
                                            input int nb);
    logic [63:0] mask;
    mask = (64'd1 << nb) - 64'd1;
    return ((64'(re) & mask) << nb) | (64'(im) & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cbfly2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cbfly2 : registered complex radix-2 butterfly, sum = a+b, dif = a-b,        |
// |          one bit of growth per component so nothing is lost.               |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module cbfly2 #(
  parameter int W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2*W-1:0]   a,
  input  logic [2*W-1:0]   b,
  output logic [2*W+1:0]   sum,
  output logic [2*W+1:0]   dif
);

  logic signed [W:0] a_re;
  logic signed [W:0] a_im;
  logic signed [W:0] b_re;
  logic signed [W:0] b_im;

  assign a_re = {a[2*W-1], a[2*W-1:W]};
  assign a_im = {a[W-1],   a[W-1:0]};
  assign b_re = {b[2*W-1], b[2*W-1:W]};
  assign b_im = {b[W-1],   b[W-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
      dif <= '0;
    end else begin
      sum <= {a_re + b_re, a_im + b_im};
      dif <= {a_re - b_re, a_im - b_im};
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifft4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifft4 : fully pipelined 4-point inverse DFT with fixed 1/4 scaling,         |
// |         output rounding/truncation and saturation. Build option:           |
// |         IFFT4_ROUND_EN selects round-half-up instead of truncation.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module ifft4
  import fft_pkg::*;
#(
  parameter int NB_INPUT   = NB_INPUT_DEF,
  parameter int NBF_INPUT  = NBF_INPUT_DEF,
  parameter int NB_OUTPUT  = NB_OUTPUT_DEF,
  parameter int NBF_OUTPUT = NBF_OUTPUT_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic [2*NB_INPUT-1:0]  i_x0,
  input  logic [2*NB_INPUT-1:0]  i_x1,
  input  logic [2*NB_INPUT-1:0]  i_x2,
  input  logic [2*NB_INPUT-1:0]  i_x3,
  output logic                   o_valid,
  output logic [2*NB_OUTPUT-1:0] o_x0,
  output logic [2*NB_OUTPUT-1:0] o_x1,
  output logic [2*NB_OUTPUT-1:0] o_x2,
  output logic [2*NB_OUTPUT-1:0] o_x3,
  output logic                   o_sat
);

  localparam int W1   = NB_INPUT + 1;
  localparam int W2   = NB_INPUT + 2;
  localparam int WQ   = W2 + 1;
  localparam int DROP = NBF_INPUT + 2 - NBF_OUTPUT;
  localparam int RND  = (1 << DROP) >> 1;
  localparam logic signed [WQ-1:0] Q_MAX = WQ'((1 << (NB_OUTPUT - 1)) - 1);
  localparam logic signed [WQ-1:0] Q_MIN = WQ'(-(1 << (NB_OUTPUT - 1)));

  logic [2*NB_INPUT-1:0] in0, in1, in2, in3;
  logic [LATENCY-2:0]    vld;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      in0 <= '0;
      in1 <= '0;
      in2 <= '0;
      in3 <= '0;
      vld <= '0;
    end else begin
      in0 <= i_x0;
      in1 <= i_x1;
      in2 <= i_x2;
      in3 <= i_x3;
      vld <= {vld[LATENCY-3:0], i_valid};
    end
  end

  logic [2*W1-1:0] s_a, s_b, s_c, s_d, jd;
  logic [2*W2-1:0] y0, y1, y2, y3;

  cbfly2 #(.W(NB_INPUT)) u_bf_02 (.clk(i_clk), .rst(i_rst), .a(in0), .b(in2), .sum(s_a), .dif(s_b));
  cbfly2 #(.W(NB_INPUT)) u_bf_13 (.clk(i_clk), .rst(i_rst), .a(in1), .b(in3), .sum(s_c), .dif(s_d));

  // j*d = (-d.im, d.re); -d.im always fits since d.im never reaches the most negative code
  assign jd = (2*W1)'(cplx_pack(-cplx_im(64'(s_d), W1), cplx_re(64'(s_d), W1), W1));

  cbfly2 #(.W(W1)) u_bf_ac (.clk(i_clk), .rst(i_rst), .a(s_a), .b(s_c), .sum(y0), .dif(y2));
  cbfly2 #(.W(W1)) u_bf_bd (.clk(i_clk), .rst(i_rst), .a(s_b), .b(jd),  .sum(y1), .dif(y3));

  // Result is {saturated, value}; the 1/4 scale is free, only the fraction point moves.
  function automatic logic [NB_OUTPUT:0] quant(input logic signed [W2-1:0] v);
    logic signed [WQ-1:0] e;
    logic                 sat;
    e = WQ'(v);
`ifdef IFFT4_ROUND_EN
    e = e + WQ'(RND);
`else
    e = e + WQ'(0 * RND);
`endif
    e   = e >>> DROP;
    sat = 1'b0;
    if (e > Q_MAX) begin
      e   = Q_MAX;
      sat = 1'b1;
    end else if (e < Q_MIN) begin
      e   = Q_MIN;
      sat = 1'b1;
    end
    return {sat, NB_OUTPUT'(e)};
  endfunction

  logic signed [W2-1:0]  comp [8];
  logic [NB_OUTPUT:0]    q    [8];

  always_comb begin
    comp[0] = W2'(cplx_re(64'(y0), W2));
    comp[1] = W2'(cplx_im(64'(y0), W2));
    comp[2] = W2'(cplx_re(64'(y1), W2));
    comp[3] = W2'(cplx_im(64'(y1), W2));
    comp[4] = W2'(cplx_re(64'(y2), W2));
    comp[5] = W2'(cplx_im(64'(y2), W2));
    comp[6] = W2'(cplx_re(64'(y3), W2));
    comp[7] = W2'(cplx_im(64'(y3), W2));
    for (int i = 0; i < 8; i++) begin
      q[i] = quant(comp[i]);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_sat   <= 1'b0;
      o_x0    <= '0;
      o_x1    <= '0;
      o_x2    <= '0;
      o_x3    <= '0;
    end else begin
      o_valid <= vld[LATENCY-2];
      o_x0    <= {q[0][NB_OUTPUT-1:0], q[1][NB_OUTPUT-1:0]};
      o_x1    <= {q[2][NB_OUTPUT-1:0], q[3][NB_OUTPUT-1:0]};
      o_x2    <= {q[4][NB_OUTPUT-1:0], q[5][NB_OUTPUT-1:0]};
      o_x3    <= {q[6][NB_OUTPUT-1:0], q[7][NB_OUTPUT-1:0]};
      o_sat   <= q[0][NB_OUTPUT] | q[1][NB_OUTPUT] | q[2][NB_OUTPUT] | q[3][NB_OUTPUT] |
                 q[4][NB_OUTPUT] | q[5][NB_OUTPUT] | q[6][NB_OUTPUT] | q[7][NB_OUTPUT];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifft4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ifft4 : directed self-checking bench for ifft4 (default widths).         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_ifft4;

  typedef logic [3:0][19:0] frame_t;
  typedef struct packed { logic sat; logic [3:0][15:0] x; } out_t;
  typedef struct { int it; out_t v; } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [19:0] x0, x1, x2, x3;
  logic        ov, osat;
  logic [15:0] y0, y1, y2, y3;

  int checks   = 0;
  int failures = 0;

  frame_t stream [8];
  exp_t   q [$];

  always #5 clk = ~clk;

  ifft4 dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid),
    .i_x0(x0), .i_x1(x1), .i_x2(x2), .i_x3(x3),
    .o_valid(ov), .o_x0(y0), .o_x1(y1), .o_x2(y2), .o_x3(y3), .o_sat(osat)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] cin(input int re, input int im);
    logic [31:0] r, i;
    r = re; i = im;
    return {r[9:0], i[9:0]};
  endfunction

  function automatic logic [15:0] cout(input int re, input int im);
    logic [31:0] r, i;
    r = re; i = im;
    return {r[7:0], i[7:0]};
  endfunction

  function automatic frame_t mkf(input int r0, input int i0, input int r1, input int i1,
                                 input int r2, input int i2, input int r3, input int i3);
    frame_t f;
    f[0] = cin(r0, i0); f[1] = cin(r1, i1); f[2] = cin(r2, i2); f[3] = cin(r3, i3);
    return f;
  endfunction

  function automatic int qnt(input int v, output logic s);
`ifdef IFFT4_ROUND_EN
    v = v + 2;
`endif
    v = v >>> 2;
    s = 1'b0;
    if (v > 127) begin v = 127; s = 1'b1; end
    else if (v < -128) begin v = -128; s = 1'b1; end
    return v;
  endfunction

  // Direct inverse DFT: x[n] = sum_k X[k] * j^(n*k), then /4 and quantise.
  function automatic out_t model(input frame_t f);
    int re [4];
    int im [4];
    int sr, si, qr, qi;
    logic s1, s2;
    out_t o;
    o = '0;
    for (int k = 0; k < 4; k++) begin
      re[k] = int'(signed'(f[k][19:10]));
      im[k] = int'(signed'(f[k][9:0]));
    end
    for (int n = 0; n < 4; n++) begin
      sr = 0; si = 0;
      for (int k = 0; k < 4; k++) begin
        case ((n * k) % 4)
          0: begin sr += re[k]; si += im[k]; end
          1: begin sr -= im[k]; si += re[k]; end
          2: begin sr -= re[k]; si -= im[k]; end
          default: begin sr += im[k]; si -= re[k]; end
        endcase
      end
      qr = qnt(sr, s1);
      qi = qnt(si, s2);
      o.x[n] = cout(qr, qi);
      o.sat  = o.sat | s1 | s2;
    end
    return o;
  endfunction

  task automatic drive(input frame_t f, input logic v);
    valid = v;
    x0 = f[0]; x1 = f[1]; x2 = f[2]; x3 = f[3];
  endtask

  task automatic check_out(input string tag, input out_t e);
    check_eq({tag, "_x0"},  32'(y0),   32'(e.x[0]));
    check_eq({tag, "_x1"},  32'(y1),   32'(e.x[1]));
    check_eq({tag, "_x2"},  32'(y2),   32'(e.x[2]));
    check_eq({tag, "_x3"},  32'(y3),   32'(e.x[3]));
    check_eq({tag, "_sat"}, 32'(osat), 32'(e.sat));
  endtask

  // One frame in, then verify o_valid stays low for 3 cycles and pulses on the 4th.
  task automatic run_single(input string tag, input frame_t f, input out_t e);
    @(negedge clk);
    drive(f, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) drive('0, 1'b0);
      check_eq({tag, "_valid"}, 32'(ov), 32'(c == 4));
    end
    check_out(tag, e);
    @(negedge clk);
    check_eq({tag, "_pulse"}, 32'(ov), 32'd0);
  endtask

  task automatic run_stream(input string tag, input int n, input int rst_iter);
    logic ev;
    q.delete();
    for (int it = 0; it < n + 8; it++) begin
      @(negedge clk);
      ev = (q.size() > 0) && (q[0].it == it);
      check_eq({tag, "_valid"}, 32'(ov), 32'(ev));
      if (ev && ov) check_out(tag, q[0].v);
      if (ev) void'(q.pop_front());
      if (it == rst_iter) begin
        rst = 1'b1;
        #1;
        check_eq({tag, "_rst_valid"}, 32'(ov),   32'd0);
        check_eq({tag, "_rst_x0"},    32'(y0),   32'd0);
        check_eq({tag, "_rst_sat"},   32'(osat), 32'd0);
        q.delete();
      end
      if (it < n) begin
        drive(stream[it], 1'b1);
        q.push_back('{it + 4, model(stream[it])});
      end else begin
        drive('0, 1'b0);
      end
      if (it == rst_iter) begin
        #2;
        rst = 1'b0;
      end
    end
    check_eq({tag, "_drain"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    frame_t f;
    out_t   e;

    stream[0] = mkf(100, -50, 30, 20, -70, 10, 5, -5);
    stream[1] = mkf(511, 511, 511, 511, 511, 511, 511, 511);
    stream[2] = mkf(-512, 0, -512, 0, -512, 0, -512, 0);
    stream[3] = mkf(1, 2, 3, -4, -5, 6, 7, -8);
    stream[4] = mkf(0, 300, -300, 0, 0, -300, 300, 0);
    stream[5] = mkf(-1, -1, 0, 0, 0, 0, 0, 0);
    stream[6] = mkf(255, -255, 128, 64, -64, -128, 17, -33);
    stream[7] = mkf(-3, 3, 3, -3, 6, 6, -6, -6);

    rst = 1'b1;
    drive('0, 1'b0);
    #2;
    check_eq("reset_valid", 32'(ov),   32'd0);
    check_eq("reset_sat",   32'(osat), 32'd0);
    check_eq("reset_x0",    32'(y0),   32'd0);
    check_eq("reset_x1",    32'(y1),   32'd0);
    check_eq("reset_x2",    32'(y2),   32'd0);
    check_eq("reset_x3",    32'(y3),   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    f = mkf(128, 0, 0, 0, 0, 0, 0, 0);
    e.sat = 1'b0;
    e.x[0] = cout(32, 0); e.x[1] = cout(32, 0); e.x[2] = cout(32, 0); e.x[3] = cout(32, 0);
    run_single("impulse", f, e);

    f = mkf(0, 0, 128, 0, 0, 0, 0, 0);
    e.sat = 1'b0;
    e.x[0] = cout(32, 0); e.x[1] = cout(0, 32); e.x[2] = cout(-32, 0); e.x[3] = cout(0, -32);
    run_single("bin1", f, e);

    f = mkf(511, 0, 511, 0, 511, 0, 511, 0);
    e.sat = 1'b1;
    e.x[0] = cout(127, 0); e.x[1] = cout(0, 0); e.x[2] = cout(0, 0); e.x[3] = cout(0, 0);
    run_single("satur", f, e);

    f = mkf(2, -2, 0, 0, 0, 0, 0, 0);
    e.sat = 1'b0;
`ifdef IFFT4_ROUND_EN
    e.x[0] = cout(1, 0); e.x[1] = cout(1, 0); e.x[2] = cout(1, 0); e.x[3] = cout(1, 0);
`else
    e.x[0] = cout(0, -1); e.x[1] = cout(0, -1); e.x[2] = cout(0, -1); e.x[3] = cout(0, -1);
`endif
    run_single("lsb", f, e);

    run_stream("b2b", 6, -1);
    run_stream("midrst", 8, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
